rx_frame_ctrl: RTL
==================

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter PARITY_MODE, default 1, parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, number of stop bits, legal values 1 or 2.
REQ-004 SHALL have parameter OVERSAMPLE, default 16, baud_tick pulses per bit, even, legal range 4..64.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port rx_serial  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-010 SHALL have port rx_data  output  DATA_BITS  received word, LSB first on the line.
REQ-011 SHALL have port rx_valid  output  1  rx_data and error flags valid.
REQ-012 SHALL have port parity_error  output  1  parity mismatch on the held word.
REQ-013 SHALL have port framing_error  output  1  any stop bit sampled low on the held word.
REQ-014 SHALL have port overrun_error  output  1  sticky; a frame completed while rx_valid was high.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL pass rx_serial through a 2-flop synchroniser (reset value 1); all references to the line below mean the synchronised value.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP; state and the tick/bit counters advance only on cycles with baud_tick high, except the IDLE edge detect in REQ-018.
REQ-018 IDLE: a high-to-low transition of the line SHALL move to START and clear the tick counter.
REQ-019 START: at tick count OVERSAMPLE/2-1, line low SHALL go to DATA and clear counters; line high SHALL be treated as a false start and return to IDLE with no flags changed.
REQ-020 DATA: each bit SHALL be sampled at tick count OVERSAMPLE-1 after the previous sample point (mid-bit), shifted into the data register LSB first; after DATA_BITS samples go to PARITY if PARITY_MODE!=0, else STOP.
REQ-021 PARITY: one sample SHALL be taken; error = (XOR of data bits XOR sampled bit) for even, its inverse for odd; then go to STOP.
REQ-022 STOP: STOP_BITS samples SHALL be taken at one-bit spacing; any low sample sets the frame's framing flag; after the last sample go to IDLE (mid stop bit, enabling back-to-back frames).
REQ-023 On the clk cycle after the last stop sample, rx_data, parity_error, framing_error SHALL load and rx_valid SHALL assert.
REQ-024 rx_valid, rx_data and per-frame flags SHALL hold stable until the cycle after rx_valid and rx_ready are both high, when rx_valid clears.
REQ-025 If a frame completes while rx_valid is high and not being accepted that cycle, the new frame SHALL be discarded, held data kept, overrun_error set.
REQ-026 If completion coincides with acceptance, the new frame SHALL load and rx_valid SHALL remain high; no overrun.
REQ-027 overrun_error SHALL clear only on reset or on an accepted handshake.
REQ-028 PARITY_MODE=0 SHALL force parity_error to 0.
REQ-029 Counters SHALL wrap within their range; no state other than the five listed is reachable, and any illegal encoding SHALL return to IDLE on the next clk.

Reset
REQ-030 reset high SHALL immediately force state IDLE, counters 0, synchroniser flops 1, rx_data 0, rx_valid 0, all error flags 0, busy 0.
REQ-031 reset asserted mid-frame SHALL abandon the frame with no rx_valid; reception resumes on the first falling edge after reset deasserts.

Verification
REQ-032 Defaults, send 0xA5 with correct even parity, rx_ready=1 -> rx_valid pulses one cycle, rx_data=0xA5, all errors 0.
REQ-033 PARITY_MODE=2, DATA_BITS=7, send 0x3C with even-parity bit -> rx_data=0x3C, parity_error=1.
REQ-034 STOP_BITS=2, second stop bit driven low, byte 0x5A -> rx_data=0x5A, framing_error=1.
REQ-035 Low glitch of OVERSAMPLE/4 ticks on idle line -> busy pulses, returns to IDLE, rx_valid stays 0.
REQ-036 rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun_error=1; raise rx_ready -> rx_valid clears, overrun_error clears.
REQ-037 Assert reset during DATA bit 3 of 0xFF -> outputs zero immediately, no rx_valid; next frame 0x81 received correctly.

Source files
------------

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: oversampled asynchronous serial receiver.
// Frame format: start bit, DATA_BITS data bits (LSB first), optional parity
// bit, STOP_BITS stop bits. The received word is held behind a valid/ready
// handshake; a frame that completes while the previous word is still held
// and not being taken is dropped and flagged as an overrun.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line idle, waiting for a high-to-low transition
// S_START  | timing to mid start bit to confirm it is still low
// S_DATA   | sampling data bits at mid-bit, shifting in LSB first
// S_PARITY | sampling the parity bit
// S_STOP   | sampling stop bits; leaves mid last stop bit
module rx_frame_ctrl #(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 1,
   parameter int STOP_BITS   = 1,
   parameter int OVERSAMPLE  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_serial,
   input  logic                 baud_tick,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_error,
   output logic                 framing_error,
   output logic                 overrun_error,
   output logic                 busy
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(OVERSAMPLE - 1);
   localparam logic [3:0] BIT_LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] BIT_LAST_STOP = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic                  sync1_q, sync1_d;
   logic                  sync2_q, sync2_d;
   logic                  line_prev_q, line_prev_d;
   logic [TICK_W-1:0]     tick_q, tick_d;
   logic [3:0]            bit_q, bit_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic                  frame_pe_q, frame_pe_d;
   logic                  frame_fe_q, frame_fe_d;
   logic                  done_q, done_d;
   logic [DATA_BITS-1:0]  data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  pe_q, pe_d;
   logic                  fe_q, fe_d;
   logic                  ovr_q, ovr_d;

   logic                  line;
   logic                  fall_det;
   logic                  half_hit;
   logic                  full_hit;
   logic                  accept;

   assign line = sync2_q;

   // State register plus all datapath flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         line_prev_q <= 1'b1;
         tick_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         frame_pe_q  <= 1'b0;
         frame_fe_q  <= 1'b0;
         done_q      <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         pe_q        <= 1'b0;
         fe_q        <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         line_prev_q <= line_prev_d;
         tick_q      <= tick_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         frame_pe_q  <= frame_pe_d;
         frame_fe_q  <= frame_fe_d;
         done_q      <= done_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         pe_q        <= pe_d;
         fe_q        <= fe_d;
         ovr_q       <= ovr_d;
      end
   end

   // Next-state decode; unknown encodings fall back to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (fall_det) state_d = S_START;
         S_START:  if (baud_tick && half_hit) state_d = line ? S_IDLE : S_DATA;
         S_DATA:   if (baud_tick && full_hit && bit_q == BIT_LAST_DATA)
                      state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (baud_tick && full_hit) state_d = S_STOP;
         S_STOP:   if (baud_tick && full_hit && bit_q == BIT_LAST_STOP) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM outputs and sample-point strobes.
   always_comb begin
      busy     = (state_q != S_IDLE);
      fall_det = line_prev_q & ~line;
      half_hit = (tick_q == TICK_HALF);
      full_hit = (tick_q == TICK_FULL);
   end

   // Synchroniser, counters, shift register and per-frame flags.
   always_comb begin
      sync1_d     = rx_serial;
      sync2_d     = sync1_q;
      line_prev_d = sync2_q;
      tick_d      = tick_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      frame_pe_d  = frame_pe_q;
      frame_fe_d  = frame_fe_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            tick_d = '0;
            bit_d  = '0;
            if (fall_det) begin
               frame_pe_d = 1'b0;
               frame_fe_d = 1'b0;
            end
         end
         S_START: begin
            if (baud_tick) begin
               if (half_hit) begin
                  tick_d = '0;
                  bit_d  = '0;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               if (full_hit) begin
                  tick_d  = '0;
                  shift_d = {line, shift_q[DATA_BITS-1:1]};
                  bit_d   = (bit_q == BIT_LAST_DATA) ? 4'd0 : bit_q + 4'd1;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (baud_tick) begin
               if (full_hit) begin
                  tick_d = '0;
                  if (PARITY_MODE == 1)      frame_pe_d = ^shift_q ^ line;
                  else if (PARITY_MODE == 2) frame_pe_d = ~(^shift_q ^ line);
                  else                       frame_pe_d = 1'b0;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         S_STOP: begin
            if (baud_tick) begin
               if (full_hit) begin
                  tick_d = '0;
                  if (!line) frame_fe_d = 1'b1;
                  if (bit_q == BIT_LAST_STOP) begin
                     bit_d  = '0;
                     done_d = 1'b1;
                  end else begin
                     bit_d = bit_q + 4'd1;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         default: begin
            tick_d = '0;
            bit_d  = '0;
         end
      endcase
   end

   // Output holding register with valid/ready handshake and overrun tracking.
   always_comb begin
      accept  = valid_q & rx_ready;
      data_d  = data_q;
      valid_d = valid_q;
      pe_d    = pe_q;
      fe_d    = fe_q;
      ovr_d   = ovr_q;
      if (accept) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
      if (done_q) begin
         if (!valid_q || accept) begin
            data_d  = shift_q;
            pe_d    = frame_pe_q;
            fe_d    = frame_fe_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   assign rx_data       = data_q;
   assign rx_valid      = valid_q;
   assign parity_error  = (PARITY_MODE != 0) & pe_q;
   assign framing_error = fe_q;
   assign overrun_error = ovr_q;

endmodule
